// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder: MMIO map,
// default RAM depth and the byte-lane merge used by writes and forwarding.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_DEFAULT = 1024;
  localparam logic [31:0] DMEM_MMIO_BASE     = 32'hFFFF_0000;

  localparam logic [3:0] DMEM_OFF_LED   = 4'h0;
  localparam logic [3:0] DMEM_OFF_CC_LO = 4'h4;
  localparam logic [3:0] DMEM_OFF_CC_HI = 4'h8;
  localparam logic [3:0] DMEM_OFF_ZERO  = 4'hC;

  function automatic logic [31:0] dmem_merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] merged;
    merged = old_word;
    for (int lane = 0; lane < 4; lane++) begin
      if (strb[lane]) begin
        merged[8*lane +: 8] = new_word[8*lane +: 8];
      end else begin
        merged[8*lane +: 8] = old_word[8*lane +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Bus between a core's data port and the memory responder.
interface data_memory_if;
  logic [3:0]  MemWriteEnable;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic [31:0] data_in;

  modport mem (input MemWriteEnable, addr_out, data_out, output data_in);
  modport cpu (output MemWriteEnable, addr_out, data_out, input data_in);
endinterface

// File: rtl/dmem_store_buffer.sv
// One-entry posted-write buffer: holds the last RAM write for one cycle,
// commits it to the array on the next edge and forwards it to matching reads.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic [3:0]       wr_strb_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [31:0]      rd_array_word_i,
  output logic [31:0]      rd_data_o,
  output logic             commit_en_o,
  output logic [IDX_W-1:0] commit_idx_o,
  output logic [31:0]      commit_data_o,
  output logic [3:0]       commit_strb_o
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       strb_q, strb_d;

  // Entry lives exactly one cycle unless a new write reloads it.
  always_comb begin
    valid_d = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    strb_d  = strb_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      idx_d   = wr_idx_i;
      data_d  = wr_data_i;
      strb_d  = wr_strb_i;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      data_q  <= 32'h0000_0000;
      strb_q  <= 4'h0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  // Forward buffered lanes over the array word for a matching read.
  always_comb begin
    rd_data_o = rd_array_word_i;
    if (valid_q && (idx_q == rd_idx_i)) begin
      rd_data_o = dmem_merge_bytes(rd_array_word_i, data_q, strb_q);
    end else begin
      rd_data_o = rd_array_word_i;
    end
  end

  assign commit_en_o   = valid_q;
  assign commit_idx_o  = idx_q;
  assign commit_data_o = data_q;
  assign commit_strb_o = strb_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word RAM with a posted store buffer plus a 16-byte
// MMIO window (LED register, 64-bit cycle counter, zero register).
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter logic [31:0] MMIO_BASE   = DMEM_MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  data_memory_if.mem  dmem,
  output logic [15:0] led
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [15:0]   led_q, led_d;
  logic [63:0]   cycle_count_q, cycle_count_d;

  logic          is_mmio_s;
  logic          any_wr_s;
  logic          ram_wr_s;
  logic [AW-1:0] ram_idx_s;
  logic [3:0]    mmio_off_s;
  logic [31:0]   ram_rdata_s;
  logic [31:0]   mmio_rdata_s;

  logic          commit_en_s;
  logic [AW-1:0] commit_idx_s;
  logic [31:0]   commit_data_s;
  logic [3:0]    commit_strb_s;

  assign is_mmio_s  = (dmem.addr_out[31:4] == MMIO_BASE[31:4]);
  assign any_wr_s   = (dmem.MemWriteEnable != 4'h0);
  assign ram_wr_s   = any_wr_s && !is_mmio_s;
  assign ram_idx_s  = dmem.addr_out[AW+1:2];
  assign mmio_off_s = {dmem.addr_out[3:2], 2'b00};

  dmem_store_buffer #(.IDX_W(AW)) u_store_buffer (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en_i         (ram_wr_s),
    .wr_idx_i        (ram_idx_s),
    .wr_data_i       (dmem.data_out),
    .wr_strb_i       (dmem.MemWriteEnable),
    .rd_idx_i        (ram_idx_s),
    .rd_array_word_i (mem_q[ram_idx_s]),
    .rd_data_o       (ram_rdata_s),
    .commit_en_o     (commit_en_s),
    .commit_idx_o    (commit_idx_s),
    .commit_data_o   (commit_data_s),
    .commit_strb_o   (commit_strb_s)
  );

  // Array is never reset; only committed lanes are written.
  always_ff @(posedge clk) begin
    if (commit_en_s) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (commit_strb_s[lane]) begin
          mem_q[commit_idx_s][8*lane +: 8] <= commit_data_s[8*lane +: 8];
        end
      end
    end
  end

  // LED write: only lanes 0-1 exist, upper strobes are dropped.
  always_comb begin
    led_d = led_q;
    if (any_wr_s && is_mmio_s && (mmio_off_s == DMEM_OFF_LED)) begin
      led_d[7:0]  = dmem.MemWriteEnable[0] ? dmem.data_out[7:0]  : led_q[7:0];
      led_d[15:8] = dmem.MemWriteEnable[1] ? dmem.data_out[15:8] : led_q[15:8];
    end else begin
      led_d = led_q;
    end
  end

  assign cycle_count_d = cycle_count_q + 64'd1;

  // MMIO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q         <= 16'h0000;
      cycle_count_q <= 64'd0;
    end else begin
      led_q         <= led_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // MMIO read decode.
  always_comb begin
    mmio_rdata_s = 32'h0000_0000;
    case (mmio_off_s)
      DMEM_OFF_LED:   mmio_rdata_s = {16'h0000, led_q};
      DMEM_OFF_CC_LO: mmio_rdata_s = cycle_count_q[31:0];
      DMEM_OFF_CC_HI: mmio_rdata_s = cycle_count_q[63:32];
      DMEM_OFF_ZERO:  mmio_rdata_s = 32'h0000_0000;
      default:        mmio_rdata_s = 32'h0000_0000;
    endcase
  end

  assign dmem.data_in = is_mmio_s ? mmio_rdata_s : ram_rdata_s;
  assign led          = led_q;

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the RAM size in 32-bit words and SHALL be a power of two.
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_0000, SHALL set the base of the 16-byte MMIO window.
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port dmem  data_memory_if.mem  SHALL be the bus: MemWriteEnable[3:0] (byte-lane write strobes), addr_out[31:0], data_out[31:0] (write data), and data_in[31:0] (read data returned).
REQ-006 Port led  output  16  SHALL be the LED register contents.

Function
REQ-007 addr_out[1:0] SHALL be ignored; the RAM index SHALL be addr_out[log2(DEPTH_WORDS)+1:2], so out-of-range addresses wrap.
REQ-008 An address SHALL be MMIO when addr_out[31:4] equals MMIO_BASE[31:4]; otherwise it SHALL be RAM.
REQ-009 Reads SHALL be combinational: data_in SHALL reflect the current addr_out in the same cycle, with no handshake and no stall.
REQ-010 A RAM write (MemWriteEnable != 0, RAM address) SHALL be posted into a one-entry store buffer holding word index, data and strobes; the buffer SHALL be loaded at the same clock edge.
REQ-011 On every edge with the buffer valid, the buffer SHALL commit its strobed bytes to the array; a new write on that edge SHALL reload the buffer; otherwise valid SHALL clear.
REQ-012 A RAM read SHALL merge the buffered bytes over the array word, lane by lane per strobe, when the buffer is valid and its index matches.
REQ-013 A write and a read in the same cycle SHALL return pre-write data; the new data SHALL be visible from the next cycle.
REQ-014 MMIO offset 0x0 (LED) SHALL be read/write: lanes 0-1 SHALL update led[15:0] at the edge; lanes 2-3 SHALL be ignored; a read SHALL return {16'h0, led}.
REQ-015 MMIO offset 0x4 SHALL read cycle_count[31:0], and offset 0x8 SHALL read cycle_count[63:32]; writes to both SHALL be ignored.
REQ-016 MMIO offset 0xC SHALL read 32'h0 and ignore writes.
REQ-017 MMIO writes SHALL bypass the store buffer and SHALL never enter the RAM.
REQ-018 cycle_count SHALL be 64-bit, SHALL increment by 1 every cycle, and SHALL wrap from all-ones to 0.
REQ-019 A cycle_count read SHALL return the value registered before that cycle's edge.

Reset
REQ-020 With rst_n low, the buffer valid SHALL be 0, led SHALL be 16'h0, and cycle_count SHALL be 0, immediately and without a clock.
REQ-021 RAM contents SHALL NOT be reset.
REQ-022 A write pending in the buffer when reset asserts SHALL be discarded.
REQ-023 During reset, data_in SHALL show the raw array word for RAM addresses, and 0 or the reset register values for MMIO addresses.

Structure
REQ-024 Package dmem_pkg SHALL hold MMIO_BASE, the MMIO offset constants, the default DEPTH_WORDS, and a byte-lane merge function.
REQ-025 The store buffer, with its commit and forwarding logic, SHALL be the sub-module dmem_store_buffer; the array and the MMIO decode SHALL stay in the top module.

Verification
REQ-026 Write 0x1234_5678 to 0x100 with strobes 4'hF; read 0x100 in the same cycle -> old value; read in the next cycle -> 0x1234_5678 (forwarded); read two cycles later -> 0x1234_5678 (from array).
REQ-027 With word 0x104 at 0xAABB_CCDD, write 0x0000_0011 with strobe 4'b0001, then read on the next cycle -> 0xAABB_CC11.
REQ-028 Back-to-back writes to 0x200 then 0x204, then read both -> each returns its own data, with no loss when the buffer reloads on commit.
REQ-029 Write 0xFFFF_ABCD with strobes 4'hF to MMIO_BASE -> led = 0xABCD, read returns 0x0000_ABCD, and RAM index 0 is unchanged; a write to MMIO_BASE+4 -> counter unaffected.
REQ-030 Assert rst_n low with a write pending to 0x300 (old value 0x5) -> 0x300 reads 0x5 after reset, led = 0, and the MMIO_BASE+4 read is 0 in the first cycle after release, 1 in the next.
REQ-031 Force cycle_count to 0x0000_0000_FFFF_FFFF; after one edge -> low reads 0 and high reads 1.
